// File: rtl/regbank_wb_scheduler_if.sv
// +--------------------------------------------------------------------------+
// | regbank_wb_scheduler_if                                                  |
// | Write-back requester, register-bank and issue-stage signal bundle.       |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

interface regbank_wb_scheduler_if #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic              alu_wr_valid;
  logic              alu_wr_ready;
  logic [IDX_W-1:0]  alu_wr_dest;
  logic [DATA_W-1:0] alu_wr_data;

  logic              ldr_wr_valid;
  logic              ldr_wr_ready;
  logic [IDX_W-1:0]  ldr_wr_dest;
  logic [DATA_W-1:0] ldr_wr_data;

  logic              rf_wr_en;
  logic [IDX_W-1:0]  rf_dest;
  logic [DATA_W-1:0] rf_wr_data;

  logic              issue_valid;
  logic              issue_writes;
  logic [IDX_W-1:0]  issue_dest;
  logic [IDX_W-1:0]  issue_src1;
  logic [IDX_W-1:0]  issue_src2;
  logic              issue_stall;

  logic [NUM_REGS-1:0] busy_mask;
  logic                spurious_err;

  // Pipeline side: drives requests and issue info, observes results.
  modport master (
    output alu_wr_valid, alu_wr_dest, alu_wr_data,
    output ldr_wr_valid, ldr_wr_dest, ldr_wr_data,
    output issue_valid, issue_writes, issue_dest, issue_src1, issue_src2,
    input  alu_wr_ready, ldr_wr_ready,
    input  rf_wr_en, rf_dest, rf_wr_data,
    input  issue_stall, busy_mask, spurious_err
  );

  // Scheduler side.
  modport slave (
    input  alu_wr_valid, alu_wr_dest, alu_wr_data,
    input  ldr_wr_valid, ldr_wr_dest, ldr_wr_data,
    input  issue_valid, issue_writes, issue_dest, issue_src1, issue_src2,
    output alu_wr_ready, ldr_wr_ready,
    output rf_wr_en, rf_dest, rf_wr_data,
    output issue_stall, busy_mask, spurious_err
  );
endinterface

`default_nettype wire

// File: rtl/regbank_wb_scheduler.sv
// +--------------------------------------------------------------------------+
// | regbank_wb_scheduler                                                     |
// | Round-robin write-back arbiter for the register bank write port plus a   |
// | busy-register scoreboard that stalls issue on RAW/WAW hazards.           |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module regbank_wb_scheduler #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  regbank_wb_scheduler_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [0:0] {
    PREF_ALU = 1'b0,
    PREF_LDR = 1'b1
  } pref_t;

  pref_t               r_pref;
  pref_t               w_pref_nxt;
  logic                w_alu_grant;
  logic                w_ldr_grant;
  logic [IDX_W-1:0]    w_sel_dest;
  logic [DATA_W-1:0]   w_sel_data;

  logic                r_wr_en;
  logic [IDX_W-1:0]    r_dest;
  logic [DATA_W-1:0]   r_wr_data;

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic                w_stall;
  logic                w_issue_fire;
  logic                r_spurious;

  // Arbitration and round-robin pointer next state.
  always_comb begin
    w_alu_grant = 1'b0;
    w_ldr_grant = 1'b0;
    w_pref_nxt  = r_pref;
    w_sel_dest  = bus.alu_wr_dest;
    w_sel_data  = bus.alu_wr_data;

    if (bus.alu_wr_valid && (!bus.ldr_wr_valid || r_pref == PREF_ALU)) begin
      w_alu_grant = 1'b1;
    end else if (bus.ldr_wr_valid) begin
      w_ldr_grant = 1'b1;
    end

    if (w_alu_grant) begin
      w_pref_nxt = PREF_LDR;
    end else if (w_ldr_grant) begin
      w_pref_nxt = PREF_ALU;
      w_sel_dest = bus.ldr_wr_dest;
      w_sel_data = bus.ldr_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pref <= PREF_ALU;
    end else begin
      r_pref <= w_pref_nxt;
    end
  end

  // Registered bank write port; dest/data hold when no grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_dest    <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_alu_grant | w_ldr_grant;
      if (w_alu_grant || w_ldr_grant) begin
        r_dest    <= w_sel_dest;
        r_wr_data <= w_sel_data;
      end
    end
  end

  // No bypass: a register being written this cycle still counts as busy.
  always_comb begin
    w_stall = bus.issue_valid &
              (r_busy[bus.issue_src1] | r_busy[bus.issue_src2] |
               (bus.issue_writes & r_busy[bus.issue_dest]));
    w_issue_fire = bus.issue_valid & bus.issue_writes & ~w_stall;
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      assign w_set[gi] = w_issue_fire & (bus.issue_dest == IDX_W'(gi));
      assign w_clr[gi] = r_wr_en & (r_dest == IDX_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_busy[gi] <= 1'b0;
        end else begin
          r_busy[gi] <= (r_busy[gi] & ~w_clr[gi]) | w_set[gi];
        end
      end
    end
  endgenerate

  // Sticky flag for a write-back that nothing was waiting on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spurious <= 1'b0;
    end else if (r_wr_en && !r_busy[r_dest]) begin
      r_spurious <= 1'b1;
    end
  end

  assign bus.alu_wr_ready = w_alu_grant;
  assign bus.ldr_wr_ready = w_ldr_grant;
  assign bus.rf_wr_en     = r_wr_en;
  assign bus.rf_dest      = r_dest;
  assign bus.rf_wr_data   = r_wr_data;
  assign bus.issue_stall  = w_stall;
  assign bus.busy_mask    = r_busy;
  assign bus.spurious_err = r_spurious;

endmodule

`default_nettype wire

// File: tb/tb_regbank_wb_scheduler.sv
// +--------------------------------------------------------------------------+
// | tb_regbank_wb_scheduler                                                  |
// | Directed self-checking bench for the write-back scheduler.               |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regbank_wb_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  regbank_wb_scheduler_if #(.NUM_REGS(16), .DATA_W(32)) bus ();

  regbank_wb_scheduler #(.NUM_REGS(16), .DATA_W(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a writing instruction with clean sources for one cycle.
  task automatic issue_reg(input logic [3:0] dest);
    @(negedge clk);
    bus.issue_valid  = 1'b1;
    bus.issue_writes = 1'b1;
    bus.issue_dest   = dest;
    bus.issue_src1   = 4'd0;
    bus.issue_src2   = 4'd0;
    tick();
    bus.issue_valid  = 1'b0;
    bus.issue_writes = 1'b0;
  endtask

  // Single uncontended write-back; returns after the rf write cycle is visible.
  task automatic single_wb(input bit is_ldr, input logic [3:0] dest, input logic [31:0] data);
    @(negedge clk);
    if (is_ldr) begin
      bus.ldr_wr_valid = 1'b1; bus.ldr_wr_dest = dest; bus.ldr_wr_data = data;
    end else begin
      bus.alu_wr_valid = 1'b1; bus.alu_wr_dest = dest; bus.alu_wr_data = data;
    end
    tick();
    bus.alu_wr_valid = 1'b0;
    bus.ldr_wr_valid = 1'b0;
  endtask

  initial begin
    bus.alu_wr_valid = 1'b0; bus.alu_wr_dest = '0; bus.alu_wr_data = '0;
    bus.ldr_wr_valid = 1'b0; bus.ldr_wr_dest = '0; bus.ldr_wr_data = '0;
    bus.issue_valid  = 1'b0; bus.issue_writes = 1'b0;
    bus.issue_dest   = '0;   bus.issue_src1   = '0;  bus.issue_src2 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_wr_en",    {31'd0, bus.rf_wr_en},     32'd0);
    chk("rst_dest",     {28'd0, bus.rf_dest},      32'd0);
    chk("rst_data",     bus.rf_wr_data,            32'd0);
    chk("rst_busy",     {16'd0, bus.busy_mask},    32'd0);
    chk("rst_spurious", {31'd0, bus.spurious_err}, 32'd0);

    // Single write to r5 through the ALU path.
    issue_reg(4'd5);
    chk("sw_busy_set", {16'd0, bus.busy_mask}, 32'h0020);
    @(negedge clk);
    bus.alu_wr_valid = 1'b1; bus.alu_wr_dest = 4'd5; bus.alu_wr_data = 32'hDEADBEEF;
    #1;
    chk("sw_alu_ready", {31'd0, bus.alu_wr_ready}, 32'd1);
    chk("sw_ldr_ready", {31'd0, bus.ldr_wr_ready}, 32'd0);
    tick();
    bus.alu_wr_valid = 1'b0;
    chk("sw_wr_en",   {31'd0, bus.rf_wr_en},  32'd1);
    chk("sw_dest",    {28'd0, bus.rf_dest},   32'd5);
    chk("sw_data",    bus.rf_wr_data,         32'hDEADBEEF);
    chk("sw_busy_wr", {16'd0, bus.busy_mask}, 32'h0020);
    tick();
    chk("sw_busy_clr",  {16'd0, bus.busy_mask}, 32'd0);
    chk("sw_wr_en_off", {31'd0, bus.rf_wr_en},  32'd0);
    chk("sw_dest_hold", {28'd0, bus.rf_dest},   32'd5);
    chk("sw_data_hold", bus.rf_wr_data,         32'hDEADBEEF);

    // LDR write to r4 returns the pointer to ALU-preferred.
    issue_reg(4'd4);
    single_wb(1'b1, 4'd4, 32'h44);
    chk("l4_dest", {28'd0, bus.rf_dest}, 32'd4);
    tick();
    chk("l4_busy", {16'd0, bus.busy_mask}, 32'd0);

    // Contention with ALU preferred.
    issue_reg(4'd1);
    issue_reg(4'd2);
    chk("c1_busy", {16'd0, bus.busy_mask}, 32'h0006);
    @(negedge clk);
    bus.alu_wr_valid = 1'b1; bus.alu_wr_dest = 4'd1; bus.alu_wr_data = 32'h11;
    bus.ldr_wr_valid = 1'b1; bus.ldr_wr_dest = 4'd2; bus.ldr_wr_data = 32'h22;
    #1;
    chk("c1_alu_ready0", {31'd0, bus.alu_wr_ready}, 32'd1);
    chk("c1_ldr_ready0", {31'd0, bus.ldr_wr_ready}, 32'd0);
    tick();
    chk("c1_dest0", {28'd0, bus.rf_dest}, 32'd1);
    chk("c1_data0", bus.rf_wr_data,       32'h11);
    bus.alu_wr_valid = 1'b0;
    #1;
    chk("c1_ldr_ready1", {31'd0, bus.ldr_wr_ready}, 32'd1);
    tick();
    bus.ldr_wr_valid = 1'b0;
    chk("c1_wr_en1", {31'd0, bus.rf_wr_en},  32'd1);
    chk("c1_dest1",  {28'd0, bus.rf_dest},   32'd2);
    chk("c1_data1",  bus.rf_wr_data,         32'h22);
    chk("c1_busy1",  {16'd0, bus.busy_mask}, 32'h0004);
    tick();
    chk("c1_busy_end", {16'd0, bus.busy_mask}, 32'd0);

    // ALU write to r6 moves the pointer to LDR, then contend again.
    issue_reg(4'd6);
    issue_reg(4'd1);
    issue_reg(4'd2);
    single_wb(1'b0, 4'd6, 32'h66);
    @(negedge clk);
    bus.alu_wr_valid = 1'b1; bus.alu_wr_dest = 4'd1; bus.alu_wr_data = 32'h33;
    bus.ldr_wr_valid = 1'b1; bus.ldr_wr_dest = 4'd2; bus.ldr_wr_data = 32'h44;
    #1;
    chk("c2_ldr_ready0", {31'd0, bus.ldr_wr_ready}, 32'd1);
    chk("c2_alu_ready0", {31'd0, bus.alu_wr_ready}, 32'd0);
    tick();
    chk("c2_dest0", {28'd0, bus.rf_dest}, 32'd2);
    chk("c2_data0", bus.rf_wr_data,       32'h44);
    bus.ldr_wr_valid = 1'b0;
    #1;
    chk("c2_alu_ready1", {31'd0, bus.alu_wr_ready}, 32'd1);
    tick();
    bus.alu_wr_valid = 1'b0;
    chk("c2_dest1", {28'd0, bus.rf_dest}, 32'd1);
    chk("c2_data1", bus.rf_wr_data,       32'h33);
    tick();
    chk("c2_busy_end", {16'd0, bus.busy_mask}, 32'd0);

    // RAW stall on r3, held through the write cycle.
    issue_reg(4'd3);
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_writes = 1'b0;
    bus.issue_dest  = 4'd0; bus.issue_src1 = 4'd3; bus.issue_src2 = 4'd0;
    bus.alu_wr_valid = 1'b1; bus.alu_wr_dest = 4'd3; bus.alu_wr_data = 32'h33;
    #1;
    chk("raw_stall0", {31'd0, bus.issue_stall}, 32'd1);
    tick();
    bus.alu_wr_valid = 1'b0;
    chk("raw_wr_en",  {31'd0, bus.rf_wr_en},    32'd1);
    chk("raw_stall1", {31'd0, bus.issue_stall}, 32'd1);
    tick();
    chk("raw_stall2", {31'd0, bus.issue_stall}, 32'd0);
    bus.issue_valid = 1'b0;

    // WAW stall on r7; writes=0 with clean sources passes.
    issue_reg(4'd7);
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_writes = 1'b1;
    bus.issue_dest  = 4'd7; bus.issue_src1 = 4'd0; bus.issue_src2 = 4'd0;
    #1;
    chk("waw_stall", {31'd0, bus.issue_stall}, 32'd1);
    bus.issue_writes = 1'b0;
    #1;
    chk("waw_nowrite", {31'd0, bus.issue_stall}, 32'd0);
    bus.issue_writes = 1'b1; bus.issue_src1 = 4'd7; bus.issue_valid = 1'b0;
    #1;
    chk("waw_novalid", {31'd0, bus.issue_stall}, 32'd0);
    bus.issue_writes = 1'b0; bus.issue_src1 = 4'd0;
    single_wb(1'b1, 4'd7, 32'h77);
    tick();
    chk("waw_busy_end", {16'd0, bus.busy_mask},    32'd0);
    chk("waw_no_err",   {31'd0, bus.spurious_err}, 32'd0);

    // Spurious write-back to r9.
    single_wb(1'b1, 4'd9, 32'h99);
    chk("sp_wr_en", {31'd0, bus.rf_wr_en}, 32'd1);
    chk("sp_dest",  {28'd0, bus.rf_dest},  32'd9);
    chk("sp_data",  bus.rf_wr_data,        32'h99);
    tick();
    chk("sp_err", {31'd0, bus.spurious_err}, 32'd1);
    repeat (3) tick();
    chk("sp_err_sticky", {31'd0, bus.spurious_err}, 32'd1);

    // Asynchronous reset mid-cycle with a write in progress.
    issue_reg(4'd1);
    issue_reg(4'd4);
    single_wb(1'b0, 4'd4, 32'hABCD);
    chk("ar_pre_busy",  {16'd0, bus.busy_mask}, 32'h0012);
    chk("ar_pre_wr_en", {31'd0, bus.rf_wr_en},  32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_wr_en",    {31'd0, bus.rf_wr_en},     32'd0);
    chk("ar_dest",     {28'd0, bus.rf_dest},      32'd0);
    chk("ar_data",     bus.rf_wr_data,            32'd0);
    chk("ar_busy",     {16'd0, bus.busy_mask},    32'd0);
    chk("ar_spurious", {31'd0, bus.spurious_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_post_wr_en", {31'd0, bus.rf_wr_en}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regbank_wb_scheduler.md
Name: regbank_wb_scheduler

Overview:
Write-back scheduler and hazard scoreboard for the 16 x 32-bit register bank. Arbitrates the bank's single write port between two write-back requesters: the ALU result path and the load-data path. Drives the bank's destination select and write data from registered outputs. Tracks in-flight destination registers so the issue stage stalls on RAW/WAW hazards.

Parameters:
NUM_REGS, 16, number of architectural registers; index width is clog2(NUM_REGS)=4
DATA_W, 32, register data width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_wr_valid  input  1  ALU write-back request
alu_wr_ready  output  1  ALU request granted this cycle (combinational)
alu_wr_dest  input  4  ALU destination register
alu_wr_data  input  DATA_W  ALU result
ldr_wr_valid  input  1  load write-back request
ldr_wr_ready  output  1  load request granted this cycle (combinational)
ldr_wr_dest  input  4  load destination register
ldr_wr_data  input  DATA_W  load data
rf_wr_en  output  1  register bank write strobe (registered)
rf_dest  output  4  register bank destination select (registered)
rf_wr_data  output  DATA_W  register bank write data (registered)
issue_valid  input  1  issue stage presents an instruction
issue_writes  input  1  instruction writes issue_dest
issue_dest  input  4  destination of issuing instruction
issue_src1  input  4  first source register
issue_src2  input  4  second source register
issue_stall  output  1  issue must hold (combinational)
busy_mask  output  NUM_REGS  scoreboard: bit i set = write to ri in flight
spurious_err  output  1  sticky: write-back to a register not marked busy

Behaviour:
- Reset (async, rst_n=0): rf_wr_en=0, rf_dest=0, rf_wr_data=0, busy_mask=0, spurious_err=0, RR pointer = ALU-preferred.
- Handshake: a transfer occurs on valid&ready. Requesters hold dest/data stable while valid and ready=0. ready is never asserted without valid.
- Arbitration: only one requester valid -> it is granted. Both valid -> round-robin. Pointer names the preferred requester; after any grant, the pointer moves to the other requester. Starvation-free: a requester waits at most 1 cycle.
- Write latency: grant in cycle N -> rf_wr_en=1 with the granted dest/data in cycle N+1. No grant -> rf_wr_en=0 in N+1; rf_dest/rf_wr_data hold their last values.
- Scoreboard set: issue_valid & issue_writes & !issue_stall -> busy[issue_dest] set at the clock edge.
- Scoreboard clear: rf_wr_en=1 -> busy[rf_dest] cleared at the end of that cycle.
- Set and clear of different registers in the same cycle both take effect. Same-register set and clear cannot coincide, because the WAW check stalls the issue.
- Stall: issue_stall = issue_valid & (busy[issue_src1] | busy[issue_src2] | (issue_writes & busy[issue_dest])).
- No bypass: a register clearing this cycle still stalls this cycle. Issue proceeds the following cycle.
- Source checks apply even when issue_writes=0. issue_stall=0 when issue_valid=0.
- spurious_err: set when rf_wr_en=1 and busy[rf_dest]=0. Cleared only by reset. The write itself is still performed.
- Reset mid-operation: a pending grant is discarded (rf_wr_en=0 next cycle), the scoreboard is wiped, and requesters must re-present after reset.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with busy_mask=0x0012 and rf_wr_en=1 -> all outputs 0 immediately, without a clock edge.
- Single write: issue dest=r5 (busy_mask=0x0020); ALU valid dest=5 data=0xDEADBEEF -> alu_wr_ready same cycle; next cycle rf_wr_en=1, rf_dest=5, rf_wr_data=0xDEADBEEF; busy_mask=0 after that edge.
- Contention: issue r1 and r2; ALU(r1,0x11) and LDR(r2,0x22) both valid, pointer=ALU -> ALU granted first, LDR next cycle; rf writes r1 then r2 on consecutive cycles. Repeat with pointer=LDR -> LDR first.
- RAW stall: r3 busy; issue src1=3 -> issue_stall=1. It stays 1 through the rf_wr_en cycle for r3 and drops the cycle after.
- WAW stall: r7 busy; issue writes=1, dest=7, sources=0,0 -> issue_stall=1. Issue with writes=0, same fields -> issue_stall=0.
- Spurious: busy_mask=0; LDR write r9 -> rf write performed, spurious_err=1 and stays 1 until reset.
